// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the datapath-facing signals of the control sequencer.
//   master : sequencer side (drives strobes, reads opcode and mem_ready)
//   slave  : datapath/RAM side (drives opcode and mem_ready, reads strobes)
//   opcode      : IR[31:27] read back from the datapath
//   mem_ready   : RAM read data valid / write accepted this cycle
//   pco..opi    : datapath register strobes
//   gra..baout  : register-select / bus encode strobes
//   mem_read/mem_write : RAM strobes
interface control_sequencer_if;
    logic [4:0] opcode;
    logic       mem_ready;
    logic       pco, pci, incpc, iri, mari, mdri, mdro;
    logic       hii, hio, loi, loo, ryi;
    logic       rzhi, rzli, rzho, rzlo, csigno, ipo, opi;
    logic       gra, grb, grc, rin, rout, baout;
    logic       mem_read, mem_write;

    modport master (
        input  opcode, mem_ready,
        output pco, pci, incpc, iri, mari, mdri, mdro,
        output hii, hio, loi, loo, ryi,
        output rzhi, rzli, rzho, rzlo, csigno, ipo, opi,
        output gra, grb, grc, rin, rout, baout,
        output mem_read, mem_write
    );

    modport slave (
        output opcode, mem_ready,
        input  pco, pci, incpc, iri, mari, mdri, mdro,
        input  hii, hio, loi, loo, ryi,
        input  rzhi, rzli, rzho, rzlo, csigno, ipo, opi,
        input  gra, grb, grc, rin, rout, baout,
        input  mem_read, mem_write
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore control unit for the single-bus 32-bit datapath: fetch
//   (T0-T2) followed by opcode-specific execute steps (T3-T7).
//   clock   : system clock, rising edge
//   clear   : synchronous active-low reset
//   start   : leave IDLE / restart from HALT
//   stop    : return to IDLE at the next instruction boundary
//   dp      : datapath strobes, opcode and RAM handshake
//   busy    : high in every state except IDLE/HALT/FAULT
//   halted, fault : status levels; illegal : 1-cycle pulse in T3
//   step    : current step index (T0=0), 0 outside T0-T7
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_T0    | PC -> MAR, PC increment
//   S_T1    | memory read into MDR, waits on mem_ready
//   S_T2    | MDR -> IR
//   S_T3-T7 | execute steps, decoded by opcode class
//   S_IDLE  | stopped, all outputs low
//   S_HALT  | halt instruction executed, waits for start
//   S_FAULT | memory handshake timed out, only clear exits
module control_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       stop,
    control_sequencer_if.master        dp,
    output logic                       busy,
    output logic                       halted,
    output logic                       fault,
    output logic                       illegal,
    output logic [3:0]                 step
);

    // T-steps encode their own step index so step can be read off directly.
    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
        S_IDLE = 4'd8, S_HALT = 4'd9, S_FAULT = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_R, C_IMM, C_MUL, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
    } cls_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    cls_t       cls;
    logic       waiting;

    always_comb begin
        cls = C_ILL;
        if      (dp.opcode == 5'd0)                         cls = C_LD;
        else if (dp.opcode == 5'd1)                         cls = C_LDI;
        else if (dp.opcode == 5'd2)                         cls = C_ST;
        else if (dp.opcode <= 5'd11)                        cls = C_R;
        else if (dp.opcode <= 5'd14)                        cls = C_IMM;
        else if (dp.opcode <= 5'd16)                        cls = C_MUL;
        else if (dp.opcode == 5'd22)                        cls = C_IN;
        else if (dp.opcode == 5'd23)                        cls = C_OUT;
        else if (dp.opcode == 5'd24)                        cls = C_NOP;
        else if (dp.opcode == 5'd25)                        cls = C_HALT;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        waiting = (state_q == S_T1) ||
                  (state_q == S_T6 && cls == C_LD) ||
                  (state_q == S_T7 && cls == C_ST);
        case (state_q)
            S_IDLE:  if (start) state_d = S_T0;
            S_T0:    state_d = stop ? S_IDLE : S_T1;
            S_T1:    if (dp.mem_ready) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                case (cls)
                    C_R, C_IMM, C_LDI, C_LD, C_ST, C_MUL: state_d = S_T4;
                    C_HALT:                               state_d = S_HALT;
                    default:                              state_d = S_T0;
                endcase
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (cls == C_LD || cls == C_ST || cls == C_MUL) ? S_T6 : S_T0;
            S_T6: begin
                if (cls == C_LD)      state_d = dp.mem_ready ? S_T7 : S_T6;
                else if (cls == C_ST) state_d = S_T7;
                else                  state_d = S_T0;
            end
            S_T7:    if (cls != C_ST || dp.mem_ready) state_d = S_T0;
            S_HALT:  if (start) state_d = S_T0;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        // Timeout wins over holding; the wait counter restarts on every step change.
        if (waiting && !dp.mem_ready && cnt_q == CNT_LAST) state_d = S_FAULT;
        if (state_d != state_q) cnt_d = '0;
        else if (waiting)       cnt_d = cnt_q + 4'd1;
        else                    cnt_d = cnt_q;
    end

    always_comb begin
        {dp.pco, dp.pci, dp.incpc, dp.iri, dp.mari, dp.mdri, dp.mdro} = '0;
        {dp.hii, dp.hio, dp.loi, dp.loo, dp.ryi} = '0;
        {dp.rzhi, dp.rzli, dp.rzho, dp.rzlo, dp.csigno, dp.ipo, dp.opi} = '0;
        {dp.gra, dp.grb, dp.grc, dp.rin, dp.rout, dp.baout} = '0;
        {dp.mem_read, dp.mem_write} = '0;
        illegal = 1'b0;
        halted  = (state_q == S_HALT);
        fault   = (state_q == S_FAULT);
        busy    = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_FAULT);
        step    = state_q[3] ? 4'd0 : state_q;
        case (state_q)
            S_T0: {dp.pco, dp.mari, dp.pci, dp.incpc} = '1;
            S_T1: {dp.mem_read, dp.mdri} = '1;
            S_T2: {dp.mdro, dp.iri} = '1;
            S_T3: begin
                case (cls)
                    C_R, C_IMM:        {dp.grb, dp.rout, dp.ryi} = '1;
                    C_LDI, C_LD, C_ST: {dp.grb, dp.baout, dp.ryi} = '1;
                    C_MUL:             {dp.gra, dp.rout, dp.ryi} = '1;
                    C_IN:              {dp.ipo, dp.gra, dp.rin} = '1;
                    C_OUT:             {dp.gra, dp.rout, dp.opi} = '1;
                    C_ILL:             illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_R:                      {dp.grc, dp.rout, dp.rzli} = '1;
                    C_IMM, C_LDI, C_LD, C_ST: {dp.csigno, dp.rzli} = '1;
                    C_MUL:                    {dp.grb, dp.rout, dp.rzhi, dp.rzli} = '1;
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_R, C_IMM, C_LDI: {dp.rzlo, dp.gra, dp.rin} = '1;
                    C_LD, C_ST:        {dp.rzlo, dp.mari} = '1;
                    C_MUL:             {dp.rzlo, dp.loi} = '1;
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD:  {dp.mem_read, dp.mdri} = '1;
                    C_ST:  {dp.gra, dp.rout, dp.mdri} = '1;
                    C_MUL: {dp.rzho, dp.hii} = '1;
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD:    {dp.mdro, dp.gra, dp.rin} = '1;
                    C_ST:    dp.mem_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
